// File: rtl/pic_host_sequencer.sv
// Host-side initiator for the 8259-style PIC: init word programming, INTA acknowledge, EOI and
// software writes. Optional VEC_CHECK_EN adds vec_err to reject vectors outside the ICW2 base.
module pic_host_sequencer #(
  parameter logic [7:0]  ICW1_VAL   = 8'h13,
  parameter logic [7:0]  ICW2_VAL   = 8'h40,
  parameter logic [7:0]  ICW3_VAL   = 8'h00,
  parameter logic [7:0]  ICW4_VAL   = 8'h03,
  parameter logic [7:0]  OCW1_VAL   = 8'h00,
  parameter int unsigned WR_PULSE   = 2,
  parameter int unsigned INTA_PULSE = 2,
  parameter int unsigned INTA_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic       A0,
  output logic       WR_n,
  output logic       INTA_n,
  output logic       init_done,
  input  logic       eoi_req,
  input  logic       sw_wr_req,
  input  logic       sw_a0,
  input  logic [7:0] sw_data,
  output logic       sw_wr_ack,
  output logic       vec_valid,
  output logic [7:0] vec,
`ifdef VEC_CHECK_EN
  output logic       vec_err,
`endif
  output logic       busy
);

  typedef enum logic [3:0] {
    StInitIcw1, StInitIcw2, StInitIcw3, StInitIcw4, StInitOcw1, StIdle,
    StWrSetup, StWrStrobe, StWrHold, StAck1, StGap, StAck2, StAckEnd
  } state_e;

  localparam state_e AfterIcw2 = !ICW1_VAL[1] ? StInitIcw3 :
                                 (ICW1_VAL[0] ? StInitIcw4 : StInitOcw1);
  localparam state_e AfterIcw3 = ICW1_VAL[0] ? StInitIcw4 : StInitOcw1;

  localparam logic [7:0] WrLast   = 8'(WR_PULSE - 1);
  localparam logic [7:0] PulseLast = 8'(INTA_PULSE - 1);
  localparam logic [7:0] GapLast  = 8'(INTA_GAP - 1);
  localparam logic [7:0] OcwEoi   = 8'h20;

  state_e     state_q, state_d, ret_q, ret_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_a0_q, wr_a0_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_sw_q, wr_sw_d;
  logic       int_s1_q, int_s2_q, armed_q;
  logic       eoi_stg_q, eoi_pend_q;
  logic       sw_stg_q, sw_stg_a0_q, sw_pend_q, sw_a0_q;
  logic [7:0] sw_stg_data_q, sw_data_q;
  logic       init_done_q, sw_wr_ack_q, vec_valid_q;
  logic [7:0] vec_q;
  logic       ack_start, eoi_start, sw_start, vec_capture;

  logic [7:0] d_out;
  logic       d_oe, a0, wr_n, inta_n;

  // Bus decode straight from state; gated with rst_n so strobes drop the instant reset asserts.
  always_comb begin
    d_out  = 8'h00;
    d_oe   = 1'b0;
    a0     = 1'b0;
    wr_n   = 1'b1;
    inta_n = 1'b1;
    unique case (state_q)
      StInitIcw1: begin d_oe = 1'b1; d_out = ICW1_VAL; a0 = 1'b0; end
      StInitIcw2: begin d_oe = 1'b1; d_out = ICW2_VAL; a0 = 1'b1; end
      StInitIcw3: begin d_oe = 1'b1; d_out = ICW3_VAL; a0 = 1'b1; end
      StInitIcw4: begin d_oe = 1'b1; d_out = ICW4_VAL; a0 = 1'b1; end
      StInitOcw1: begin d_oe = 1'b1; d_out = OCW1_VAL; a0 = 1'b1; end
      StWrSetup, StWrHold: begin d_oe = 1'b1; d_out = wr_data_q; a0 = wr_a0_q; end
      StWrStrobe: begin d_oe = 1'b1; d_out = wr_data_q; a0 = wr_a0_q; wr_n = 1'b0; end
      StAck1, StAck2: inta_n = 1'b0;
      default: ;
    endcase
  end

  assign D_out  = rst_n ? d_out : 8'h00;
  assign D_oe   = rst_n & d_oe;
  assign A0     = rst_n & a0;
  assign WR_n   = ~rst_n | wr_n;
  assign INTA_n = ~rst_n | inta_n;
  assign busy   = rst_n & (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    wr_a0_d   = wr_a0_q;
    wr_data_d = wr_data_q;
    wr_sw_d   = wr_sw_q;
    ack_start = 1'b0;
    eoi_start = 1'b0;
    sw_start  = 1'b0;
    vec_capture = 1'b0;
    unique case (state_q)
      StInitIcw1, StInitIcw2, StInitIcw3, StInitIcw4, StInitOcw1: begin
        // Init states are the setup cycle of their own write; latch the word for strobe/hold.
        state_d   = StWrStrobe;
        cnt_d     = 8'd0;
        wr_a0_d   = a0;
        wr_data_d = d_out;
        wr_sw_d   = 1'b0;
        unique case (state_q)
          StInitIcw1: ret_d = StInitIcw2;
          StInitIcw2: ret_d = AfterIcw2;
          StInitIcw3: ret_d = AfterIcw3;
          StInitIcw4: ret_d = StInitOcw1;
          default:    ret_d = StIdle;
        endcase
      end
      StIdle: begin
        if (int_s2_q && armed_q) begin
          ack_start = 1'b1;
          cnt_d     = 8'd0;
          state_d   = StAck1;
        end else if (eoi_pend_q) begin
          eoi_start = 1'b1;
          wr_a0_d   = 1'b0;
          wr_data_d = OcwEoi;
          wr_sw_d   = 1'b0;
          ret_d     = StIdle;
          state_d   = StWrSetup;
        end else if (sw_pend_q) begin
          sw_start  = 1'b1;
          wr_a0_d   = sw_a0_q;
          wr_data_d = sw_data_q;
          wr_sw_d   = 1'b1;
          ret_d     = StIdle;
          state_d   = StWrSetup;
        end
      end
      StWrSetup: begin
        cnt_d   = 8'd0;
        state_d = StWrStrobe;
      end
      StWrStrobe: begin
        if (cnt_q == WrLast) state_d = StWrHold;
        else cnt_d = cnt_q + 8'd1;
      end
      StWrHold: state_d = ret_q;
      StAck1: begin
        if (cnt_q == PulseLast) begin
          cnt_d   = 8'd0;
          state_d = StGap;
        end else cnt_d = cnt_q + 8'd1;
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = 8'd0;
          state_d = StAck2;
        end else cnt_d = cnt_q + 8'd1;
      end
      StAck2: begin
        if (cnt_q == PulseLast) begin
          vec_capture = 1'b1;
          state_d     = StAckEnd;
        end else cnt_d = cnt_q + 8'd1;
      end
      StAckEnd: state_d = StIdle;
      default:  state_d = StInitIcw1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInitIcw1;
      ret_q         <= StInitIcw2;
      cnt_q         <= 8'd0;
      wr_a0_q       <= 1'b0;
      wr_data_q     <= 8'h00;
      wr_sw_q       <= 1'b0;
      int_s1_q      <= 1'b0;
      int_s2_q      <= 1'b0;
      armed_q       <= 1'b1;
      eoi_stg_q     <= 1'b0;
      eoi_pend_q    <= 1'b0;
      sw_stg_q      <= 1'b0;
      sw_stg_a0_q   <= 1'b0;
      sw_stg_data_q <= 8'h00;
      sw_pend_q     <= 1'b0;
      sw_a0_q       <= 1'b0;
      sw_data_q     <= 8'h00;
      init_done_q   <= 1'b0;
      sw_wr_ack_q   <= 1'b0;
      vec_valid_q   <= 1'b0;
      vec_q         <= 8'h00;
`ifdef VEC_CHECK_EN
      vec_err       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      wr_a0_q   <= wr_a0_d;
      wr_data_q <= wr_data_d;
      wr_sw_q   <= wr_sw_d;
      int_s1_q  <= INT;
      int_s2_q  <= int_s1_q;
      // One request stage matches the INT synchroniser, so same-cycle events arbitrate fairly.
      eoi_stg_q <= eoi_req;
      sw_stg_q  <= sw_wr_req;
      if (sw_wr_req) begin
        sw_stg_a0_q   <= sw_a0;
        sw_stg_data_q <= sw_data;
      end
      if (ack_start)      armed_q <= 1'b0;
      else if (!int_s2_q) armed_q <= 1'b1;
      if (eoi_start)      eoi_pend_q <= 1'b0;
      else if (eoi_stg_q) eoi_pend_q <= 1'b1;
      if (sw_start) sw_pend_q <= 1'b0;
      else if (sw_stg_q && !sw_pend_q) begin
        sw_pend_q <= 1'b1;
        sw_a0_q   <= sw_stg_a0_q;
        sw_data_q <= sw_stg_data_q;
      end
      if (state_q == StWrHold && ret_q == StIdle) init_done_q <= 1'b1;
      sw_wr_ack_q <= (state_q == StWrHold) && wr_sw_q;
      vec_valid_q <= 1'b0;
`ifdef VEC_CHECK_EN
      vec_err <= 1'b0;
      if (vec_capture) begin
        if (D_in[7:3] != ICW2_VAL[7:3]) vec_err <= 1'b1;
        else begin
          vec_q       <= D_in;
          vec_valid_q <= 1'b1;
        end
      end
`else
      if (vec_capture) begin
        vec_q       <= D_in;
        vec_valid_q <= 1'b1;
      end
`endif
    end
  end

  assign init_done = init_done_q;
  assign sw_wr_ack = sw_wr_ack_q;
  assign vec_valid = vec_valid_q;
  assign vec       = vec_q;

endmodule
